// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding and the counter-width function.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceil(log2(n)), never below 1 so a counter always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand/result bus.
// master drives start/sub/a/b/cin; slave returns busy/done/sum/cout/ovf.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder.
// Ports: i_a, i_b, i_cin -> o_sum, o_cout.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one full-adder cell over WIDTH cycles.
// Ports: clk, rst_n (async active-low), bus (serial_adder_if.slave).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_if.slave        bus
);
    localparam int CW = clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_ps;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_ps_next;

    fa_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_load    = (r_state != RUN) && bus.start;
    assign w_ps_next = {w_s, r_ps[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        unique case (r_state)
            IDLE, DONE: w_next = bus.start ? RUN : IDLE;
            RUN:        w_next = w_last ? DONE : RUN;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ps    <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            // Subtract is a + ~b + 1; the +1 enters as the initial carry.
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_ps    <= '0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_ps    <= w_ps_next;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_ps_next;
                r_cout <= w_c;
                // r_carry is the carry into the MSB on the last bit.
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8).
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_serial_adder;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    serial_adder_if #(.WIDTH(8)) bus ();

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for done; no checking here.
    task automatic op(
        input  logic [7:0] ia,
        input  logic [7:0] ib,
        input  logic       ic,
        input  logic       isub,
        output logic [7:0] s,
        output logic       co,
        output logic       ov,
        output int         nbusy,
        output bit         got,
        output bit         both
    );
        @(negedge clk);
        bus.a = ia;
        bus.b = ib;
        bus.cin = ic;
        bus.sub = isub;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy = 0;
        got = 0;
        both = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.busy && bus.done) both = 1;
            if (bus.done) got = 1;
            else begin
                if (bus.busy) nbusy++;
                @(negedge clk);
            end
        end
        s = bus.sum;
        co = bus.cout;
        ov = bus.ovf;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy_done: got %b/%b want 0/0",
                     bus.busy, bus.done);
        end
        n_cmp++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_result: got %h/%b/%b want 00/0/0",
                     bus.sum, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_add_basic();
        logic [7:0] s;
        logic co, ov;
        int nb;
        bit got, both;
        op(8'd100, 8'd27, 1'b0, 1'b0, s, co, ov, nb, got, both);
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL add_basic_done: timeout, got 0 want 1");
        end
        n_cmp++;
        if (nb !== 8) begin
            n_err++;
            $display("FAIL add_basic_busy_cycles: got %0d want 8", nb);
        end
        n_cmp++;
        if (both) begin
            n_err++;
            $display("FAIL add_basic_busy_done_overlap: got 1 want 0");
        end
        n_cmp++;
        if ({s, co, ov} !== {8'd127, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL add_basic: got %h/%b/%b want 7f/0/0", s, co, ov);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL add_basic_done_pulse: got %b/%b want 0/0",
                     bus.done, bus.busy);
        end
    endtask

    task automatic test_add_carry();
        logic [7:0] s;
        logic co, ov;
        int nb;
        bit got, both;
        op(8'd200, 8'd100, 1'b0, 1'b0, s, co, ov, nb, got, both);
        n_cmp++;
        if (!got || {s, co, ov} !== {8'd44, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL add_200_100: got %h/%b/%b done=%b want 2c/1/0/1",
                     s, co, ov, got);
        end
        op(8'hFF, 8'h00, 1'b1, 1'b0, s, co, ov, nb, got, both);
        n_cmp++;
        if (!got || {s, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL add_ff_cin: got %h/%b/%b done=%b want 00/1/0/1",
                     s, co, ov, got);
        end
    endtask

    task automatic test_sub();
        logic [7:0] s;
        logic co, ov;
        int nb;
        bit got, both;
        // cin=1 must be ignored when subtracting.
        op(8'd5, 8'd7, 1'b1, 1'b1, s, co, ov, nb, got, both);
        n_cmp++;
        if (!got || {s, co, ov} !== {8'hFE, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sub_5_7: got %h/%b/%b done=%b want fe/0/0/1",
                     s, co, ov, got);
        end
        op(8'h80, 8'h01, 1'b0, 1'b1, s, co, ov, nb, got, both);
        n_cmp++;
        if (!got || {s, co, ov} !== {8'h7F, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL sub_80_1: got %h/%b/%b done=%b want 7f/1/1/1",
                     s, co, ov, got);
        end
    endtask

    task automatic test_hold();
        bit held;
        bit got;
        // Previous result is 0x7F from the subtract test.
        held = 1;
        got = 0;
        @(negedge clk);
        bus.a = 8'd127;
        bus.b = 8'd1;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.done) got = 1;
            else begin
                if (bus.sum !== 8'h7F) held = 0;
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!held) begin
            n_err++;
            $display("FAIL hold_prev_sum: got changed want held 7f");
        end
        n_cmp++;
        if (!got || {bus.sum, bus.cout, bus.ovf} !== {8'h80, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL add_127_1: got %h/%b/%b done=%b want 80/0/1/1",
                     bus.sum, bus.cout, bus.ovf, got);
        end
    endtask

    task automatic test_ignore_start();
        bit got;
        got = 0;
        @(negedge clk);
        bus.a = 8'd10;
        bus.b = 8'd20;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.a = 8'hAA;
        bus.b = 8'h11;
        bus.sub = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.done) got = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!got || {bus.sum, bus.cout, bus.ovf} !== {8'd30, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL ignore_start: got %h/%b/%b done=%b want 1e/0/0/1",
                     bus.sum, bus.cout, bus.ovf, got);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s;
        logic co, ov;
        int nb;
        int gap;
        bit got, both;
        op(8'd3, 8'd4, 1'b0, 1'b0, s, co, ov, nb, got, both);
        n_cmp++;
        if (!got || s !== 8'd7) begin
            n_err++;
            $display("FAIL b2b_first: got %h done=%b want 07/1", s, got);
        end
        // Still in the done cycle: hold start with new operands.
        bus.a = 8'd50;
        bus.b = 8'd60;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        gap = 1;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: got done=%b busy=%b want 0/1",
                     bus.done, bus.busy);
        end
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.done) got = 1;
            else begin
                @(negedge clk);
                gap++;
            end
        end
        n_cmp++;
        if (!got || gap !== 9) begin
            n_err++;
            $display("FAIL b2b_gap: got %0d done=%b want 9/1", gap, got);
        end
        n_cmp++;
        if (bus.sum !== 8'd110) begin
            n_err++;
            $display("FAIL b2b_second: got %h want 6e", bus.sum);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic co, ov;
        int nb;
        bit got, both, seen;
        @(negedge clk);
        bus.a = 8'd100;
        bus.b = 8'd27;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_mid: got b=%b d=%b s=%h c=%b o=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_mid_no_done: got activity want none");
        end
        op(8'd1, 8'd2, 1'b0, 1'b0, s, co, ov, nb, got, both);
        n_cmp++;
        if (!got || {s, co, ov} !== {8'd3, 1'b0, 1'b0} || nb !== 8) begin
            n_err++;
            $display("FAIL reset_mid_next: got %h/%b/%b nb=%0d want 03/0/0/8",
                     s, co, ov, nb);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_add_basic();
        test_add_carry();
        test_sub();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. It reuses one full-adder cell over WIDTH clock cycles to add or subtract two WIDTH-bit operands, trading latency for area. It sits beside the combinational adders as the low-area arithmetic option, with a start/busy/done handshake for use under a controlling FSM.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0: a + b + cin; 1: a − b (cin ignored); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add; sampled with start.
- busy  output  1  high while bits are being processed (state RUN).
- done  output  1  one-cycle pulse: result valid and newly updated.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Load shift register A ← a.
  - Load shift register B ← (sub ? ~b : b).
  - Load carry ← (sub ? 1 : cin).
  - Set bit counter ← 0.
  - Go to RUN.
- IDLE/DONE with start=0: go to IDLE (DONE always lasts exactly one cycle).
- RUN, each cycle:
  - The cell adds A[0], B[0] and carry.
  - The sum bit shifts into the MSB of the partial-sum register; A and B shift right.
  - carry ← cell cout; counter increments.
  - At counter = WIDTH−1, the last bit is processed and the state goes to DONE.
- On the RUN→DONE edge:
  - sum ← completed partial-sum register.
  - cout ← final carry.
  - ovf ← carry-in of the MSB bit XOR final carry.
- sum, cout and ovf change only on the RUN→DONE edge.
- start in RUN is ignored. There is no queueing and no error flag.
- Operands may change freely after the start cycle.
- Width rule: result is modulo 2^WIDTH. cout carries the extra bit. ovf is meaningful for two's-complement interpretation.

## Timing
- Reset (asynchronous, any time) forces:
  - state IDLE;
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0;
  - internal shift registers and counter cleared.
- Reset mid-RUN aborts the operation; no done pulse follows.
- Accept edge t (start=1, state IDLE or DONE):
  - busy = 1 from after t through edge t+WIDTH.
  - After edge t+WIDTH: state DONE, busy = 0, done = 1, new sum/cout/ovf visible.
  - After edge t+WIDTH+1: done = 0.
- Latency: start edge to done high is WIDTH cycles. Throughput: one operation per WIDTH+1 cycles.
- Back-to-back: start=1 during the done cycle is accepted at edge t+WIDTH+1. done still drops and busy rises in the same cycle.
- busy and done decode directly from the registered state; they are glitch-free and never high together.

## Structure
- Shared package serial_adder_pkg holds:
  - state encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - counter width function clog2(WIDTH).
- One sub-module, fa_cell: combinational 1-bit full adder (a, b, cin → sum, cout), instantiated once.
- Everything else (FSM, shift registers, counter, result registers) lives in serial_adder.

## Test plan
All scenarios use WIDTH=8.
- Add 100 + 27, cin=0 → done 8 cycles after the accept edge; sum=127, cout=0, ovf=0; busy high exactly 8 cycles.
- Add 200 + 100 → sum=44, cout=1, ovf=0. Add 0xFF + 0x00 with cin=1 → sum=0x00, cout=1, ovf=0.
- Sub 5 − 7 → sum=0xFE, cout=0 (borrow), ovf=0. Sub 0x80 − 1 → sum=0x7F, cout=1, ovf=1.
- Add 127 + 1 → sum=0x80, cout=0, ovf=1. The previous result stays on sum until this done pulse.
- Pulse start with new operands mid-RUN → ignored; result matches the original operands. Start held during the done cycle → second operation accepted, done pulses twice, 9 cycles apart.
- Assert rst_n=0 at bit 4 of a running add → all outputs 0 immediately; no done after release; the next start completes normally.
